data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of `data_memory`. It shares the single data-memory port between two requesters: port 0 is the core load/store unit and port 1 is the debug/DMA master.
- Arbitration is round-robin with a valid/ready request handshake, and each accepted request becomes one registered memory command.
- Read data is captured into a response buffer held under rsp_ready back-pressure.
- Writes into the ROM window and out-of-range accesses are rejected with an error response and never reach memory.

---
 rtl/data_memory_arbiter_pkg.sv | 33 +++
 rtl/data_memory_arbiter_rr_arbiter.sv | 36 +++
 rtl/data_memory_arbiter.sv | 166 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// data_memory_arbiter_pkg : data-memory geometry, arbiter FSM state and the
// ROM/range legality helper.                                      Rev 1.0
// ============================================================================
package data_memory_arbiter_pkg;

  localparam int RISC_V_DATA_WIDTH         = 32;
  localparam int DATA_MEMORY_ADDRESS_WIDTH = 10;
  localparam int DATA_MEMORY_ROM_DEPTH     = 256;
  localparam int DATA_MEMORY_RAM_DEPTH     = 512;
  localparam int DATA_MEMORY_TOTAL_DEPTH   = DATA_MEMORY_ROM_DEPTH + DATA_MEMORY_RAM_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } dmem_arb_state_t;

  // Zero-extend to 32 bits so the depth compare is exact for any address width
  function automatic logic dmem_access_illegal(
    input logic                                 we,
    input logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] addr
  );
    logic [31:0] addr_ext;
    addr_ext = {{(32-DATA_MEMORY_ADDRESS_WIDTH){1'b0}}, addr};
    return (we && (addr_ext < 32'(DATA_MEMORY_ROM_DEPTH))) ||
           (addr_ext >= 32'(DATA_MEMORY_TOTAL_DEPTH));
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_rr_arbiter : two-input round-robin grant; last_grant moves on advance.
//                                                                 Rev 1.0
// ============================================================================
module dmem_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_idx = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_q;
      default: grant_idx = 1'b0;
    endcase
    grant_valid  = |req_valid;
    last_grant_d = advance ? grant_idx : last_grant_q;
  end

  // Reset to 1 so port 0 wins the first conflict
  always_ff @(posedge clk) begin
    if (!rst) last_grant_q <= 1'b1;
    else      last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// data_memory_arbiter : shares the data_memory port between the LSU (port 0)
// and debug/DMA (port 1). Optional counters under DMEM_ARB_PERF_EN.  Rev 1.0
// ============================================================================
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [1:0]                             req_valid,
  output logic [1:0]                             req_ready,
  input  logic [1:0]                             req_we,
  input  logic [2*DATA_MEMORY_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [2*RISC_V_DATA_WIDTH-1:0]         req_wdata,
  output logic [1:0]                             rsp_valid,
  input  logic [1:0]                             rsp_ready,
  output logic [RISC_V_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                   rsp_err,
  output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0]   mem_address,
  output logic [RISC_V_DATA_WIDTH-1:0]           mem_w_data,
  output logic                                   mem_ctrl_w,
  output logic                                   mem_ctrl_r,
  input  logic [RISC_V_DATA_WIDTH-1:0]           mem_r_data
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]                            perf_grant0,
  output logic [31:0]                            perf_grant1,
  output logic [31:0]                            perf_conflict
`endif
);

  localparam int AW = DATA_MEMORY_ADDRESS_WIDTH;
  localparam int DW = RISC_V_DATA_WIDTH;

  dmem_arb_state_t state_q, state_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic [DW-1:0]   mem_w_data_q, mem_w_data_d;

  logic            grant_valid;
  logic            grant_idx;
  logic            handshake;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  dmem_rr_arbiter u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .advance     (handshake),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? req_we[1]             : req_we[0];
  assign sel_addr  = grant_idx ? req_addr[AW +: AW]    : req_addr[0 +: AW];
  assign sel_wdata = grant_idx ? req_wdata[DW +: DW]   : req_wdata[0 +: DW];
  assign handshake = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      port_q        <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_w_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      we_q          <= we_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_w_data_q  <= mem_w_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    we_d          = we_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_w_data_d  = mem_w_data_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          port_d  = grant_idx;
          we_d    = sel_we;
          rdata_d = '0;
          err_d   = dmem_access_illegal(sel_we, sel_addr);
          // Rejected accesses leave the memory-side registers untouched
          if (err_d) begin
            state_d = ST_RESP;
          end else begin
            mem_address_d = sel_addr;
            mem_w_data_d  = sel_wdata;
            state_d       = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:   state_d = we_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: begin
        rdata_d = mem_r_data;
        state_d = ST_RESP;
      end
      ST_RESP:    if (rsp_ready[port_q]) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (rst && (state_q == ST_IDLE) && grant_valid) req_ready[grant_idx] = 1'b1;
    if (state_q == ST_RESP)                         rsp_valid[port_q]    = 1'b1;
    mem_ctrl_w  = (state_q == ST_ISSUE) &&  we_q;
    mem_ctrl_r  = (state_q == ST_ISSUE) && !we_q;
    mem_address = mem_address_q;
    mem_w_data  = mem_w_data_q;
    rsp_rdata   = rdata_q;
    rsp_err     = err_q;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_grant0_d   = perf_grant0_q;
    perf_grant1_d   = perf_grant1_q;
    perf_conflict_d = perf_conflict_q;
    if (handshake && !grant_idx && (perf_grant0_q != '1)) perf_grant0_d = perf_grant0_q + 32'd1;
    if (handshake &&  grant_idx && (perf_grant1_q != '1)) perf_grant1_d = perf_grant1_q + 32'd1;
    if ((state_q == ST_IDLE) && (&req_valid) && (perf_conflict_q != '1))
      perf_conflict_d = perf_conflict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_grant0_q   <= perf_grant0_d;
      perf_grant1_q   <= perf_grant1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_memory_arbiter : directed bench with a behavioural data_memory
// (ROM word i reads 0xA000_0000|i, RAM is writable).              Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int AW = DATA_MEMORY_ADDRESS_WIDTH;
  localparam int DW = RISC_V_DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_w_data, mem_r_data;
  logic            rsp_err, mem_ctrl_w, mem_ctrl_r;
  logic [AW-1:0]   mem_address;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]     perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rom_writes = 0;

  data_memory_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_w_data  (mem_w_data),
    .mem_ctrl_w  (mem_ctrl_w),
    .mem_ctrl_r  (mem_ctrl_r),
    .mem_r_data  (mem_r_data)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_ctrl_w) ram[mem_address] <= mem_w_data;
    if (mem_ctrl_w && (32'(mem_address) < 32'(DATA_MEMORY_ROM_DEPTH))) rom_writes <= rom_writes + 1;
    if (mem_ctrl_r) mem_r_data <= (32'(mem_address) < 32'(DATA_MEMORY_ROM_DEPTH)) ?
                                  (32'hA000_0000 | 32'(mem_address)) : ram[mem_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request on port p and return just after its handshake edge
  task automatic send(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited = 0;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    #1;
    while (!req_ready[p] && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check_eq("handshake", 32'(req_ready[p]), 32'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    check_eq({tag, "_mem_addr"},  32'(mem_address), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_w_data, 32'd0);
    check_eq({tag, "_mem_ctrl"},  32'({mem_ctrl_w, mem_ctrl_r}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_grant;
    logic       seen_rsp;
    rst = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    req_valid = 2'b00;
    rst = 1'b1;

    // Port 0 write 0xDEADBEEF to 0x100
    send(0, 1'b1, 10'h100, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check_eq("wr_ctrl", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd2);
    check_eq("wr_addr", 32'(mem_address), 32'h100);
    check_eq("wr_data", mem_w_data, 32'hDEAD_BEEF);
    check_eq("wr_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    check_eq("wr_rsp", 32'(rsp_valid), 32'd1);
    check_eq("wr_err", 32'(rsp_err), 32'd0);
    check_eq("wr_rdata", rsp_rdata, 32'd0);
    check_eq("wr_ctrl_off", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd0);
    @(negedge clk); #1;
    check_eq("wr_rsp_done", 32'(rsp_valid), 32'd0);

    send(0, 1'b1, 10'h101, 32'hCAFE_0101);
    repeat (2) @(negedge clk);

    // Port 0 read back 0x100
    send(0, 1'b0, 10'h100, 32'd0);
    @(negedge clk); #1;
    check_eq("rd_ctrl", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd1);
    @(negedge clk); #1;
    check_eq("rd_capture_ctrl", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd0);
    check_eq("rd_capture_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    check_eq("rd_rsp", 32'(rsp_valid), 32'd1);
    check_eq("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_err", 32'(rsp_err), 32'd0);

    // Port 1 write into ROM is rejected, then ROM read
    send(1, 1'b1, 10'h010, 32'h1111_1111);
    @(negedge clk); #1;
    check_eq("rom_wr_rsp", 32'(rsp_valid), 32'd2);
    check_eq("rom_wr_err", 32'(rsp_err), 32'd1);
    check_eq("rom_wr_rdata", rsp_rdata, 32'd0);
    check_eq("rom_wr_ctrl", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd0);
    send(1, 1'b0, 10'h010, 32'd0);
    repeat (3) @(negedge clk); #1;
    check_eq("rom_rd_rsp", 32'(rsp_valid), 32'd2);
    check_eq("rom_rd_rdata", rsp_rdata, 32'hA000_0010);
    check_eq("rom_rd_err", 32'(rsp_err), 32'd0);

    // Out-of-range read
    send(0, 1'b0, 10'h300, 32'd0);
    @(negedge clk); #1;
    check_eq("oor_rsp", 32'(rsp_valid), 32'd1);
    check_eq("oor_err", 32'(rsp_err), 32'd1);
    check_eq("oor_ctrl", 32'({mem_ctrl_w, mem_ctrl_r}), 32'd0);
    @(negedge clk); #1;
    check_eq("rom_never_written", 32'(rom_writes), 32'd0);

    // Round-robin after a fresh reset: port 0 first, then alternate
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    req_we = 2'b00;
    req_addr = {10'h101, 10'h100};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 8; k++) begin
      int w = 0;
      while (req_ready == 2'b00 && w < 10) begin
        @(negedge clk); #1; w++;
      end
      exp_grant = (k % 2 == 1) ? 2'b10 : 2'b01;
      check_eq("rr_grant", 32'(req_ready), 32'(exp_grant));
      @(posedge clk); #1;
      if (k == 7) req_valid = 2'b00;
      repeat (3) @(negedge clk); #1;
      check_eq("rr_rsp", 32'(rsp_valid), 32'(exp_grant));
      check_eq("rr_rdata", rsp_rdata, (k % 2 == 1) ? 32'hCAFE_0101 : 32'hDEAD_BEEF);
    end
`ifdef DMEM_ARB_PERF_EN
    check_eq("perf_conflict", perf_conflict, 32'd8);
    check_eq("perf_grant0", perf_grant0, 32'd4);
    check_eq("perf_grant1", perf_grant1, 32'd4);
`endif

    // Response back-pressure on port 0; port 1 waits and its rsp_ready is ignored
    rsp_ready = 2'b10;
    send(0, 1'b0, 10'h100, 32'd0);
    req_we[1] = 1'b0; req_addr[AW +: AW] = 10'h101; req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_eq("bp_rsp", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b11;
    @(negedge clk); #1;
    check_eq("bp_idle_grant", 32'(req_ready), 32'd2);
    check_eq("bp_rsp_done", 32'(rsp_valid), 32'd0);
    req_valid[1] = 1'b0;

    // Reset during the ISSUE cycle of a write
    send(0, 1'b1, 10'h104, 32'h1234_5678);
    @(negedge clk); #1;
    check_eq("rst_issue_ctrl", 32'(mem_ctrl_w), 32'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    check_all_zero("rst_mid");
    rst = 1'b1;
    seen_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      seen_rsp = seen_rsp | (|rsp_valid) | mem_ctrl_w | mem_ctrl_r;
    end
    check_eq("rst_no_rsp", 32'(seen_rsp), 32'd0);
    send(0, 1'b0, 10'h100, 32'd0);
    repeat (3) @(negedge clk); #1;
    check_eq("post_rst_rsp", 32'(rsp_valid), 32'd1);
    check_eq("post_rst_rdata", rsp_rdata, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
